// File: rtl/regfile_wb_arbiter_pkg.sv
// regfile_wb_arbiter_pkg: shared types and helpers for the register-file write-back arbiter.
package regfile_wb_arbiter_pkg;
   typedef enum logic {IDLE, BURST} arb_state_t;

   localparam int DEF_ADDR_W = 4;
   localparam int DEF_DATA_W = 32;

   function automatic int src_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   typedef struct packed {
      logic [DEF_ADDR_W-1:0] addr;
      logic [DEF_DATA_W-1:0] data;
   } wb_req_t;
endpackage

// File: rtl/regfile_wb_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker; first valid bit at or after i_start, wrapping.
module rr_pick #(
   parameter int N  = 3,
   parameter int IW = 2
) (
   input  logic [N-1:0]  i_valid,
   input  logic [IW-1:0] i_start,
   output logic [N-1:0]  o_onehot,
   output logic [IW-1:0] o_idx,
   output logic          o_any
);
   int j;
   always_comb begin
      o_onehot = '0;
      o_idx    = '0;
      o_any    = 1'b0;
      j        = 0;
      // Scan from the farthest offset down so the nearest valid requester wins.
      for (int k = N - 1; k >= 0; k--) begin
         j = int'(i_start) + k;
         if (j >= N) j = j - N;
         if (i_valid[j]) begin
            o_onehot    = '0;
            o_onehot[j] = 1'b1;
            o_idx       = IW'(j);
            o_any       = 1'b1;
         end
      end
   end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin write-port arbiter with bounded per-requester bursts
// and a registered write-back stage.
module regfile_wb_arbiter
   import regfile_wb_arbiter_pkg::*;
#(
   parameter int NUM_REQ   = 3,
   parameter int ADDR_W    = 4,
   parameter int DATA_W    = 32,
   parameter int MAX_BURST = 4,
   localparam int SRC_W    = src_width(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      flush,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic                      wb_en,
   output logic [ADDR_W-1:0]         wb_addr,
   output logic [DATA_W-1:0]         wb_data,
   output logic [SRC_W-1:0]          wb_src
);
   localparam int CNT_W = $clog2(MAX_BURST + 1);
   localparam logic [SRC_W-1:0] LAST = SRC_W'(NUM_REQ - 1);

   arb_state_t         r_state;
   logic [SRC_W-1:0]   r_ptr;
   logic [SRC_W-1:0]   r_owner;
   logic [CNT_W-1:0]   r_cnt;
   logic [SRC_W-1:0]   w_owner_nxt;
   logic [SRC_W-1:0]   w_pick_nxt;
   logic [SRC_W-1:0]   w_start;
   logic [SRC_W-1:0]   w_pick_idx;
   logic [SRC_W-1:0]   w_gidx;
   logic [NUM_REQ-1:0] w_pick_oh;
   logic [NUM_REQ-1:0] w_owner_oh;
   logic [CNT_W-1:0]   w_cnt_inc;
   logic               w_pick_any;
   logic               w_keep;
   logic               w_xfer;

   assign w_owner_nxt = (r_owner == LAST) ? '0 : r_owner + 1'b1;
   assign w_pick_nxt  = (w_pick_idx == LAST) ? '0 : w_pick_idx + 1'b1;
   assign w_cnt_inc   = r_cnt + 1'b1;
   assign w_keep      = (r_state == BURST) && req_valid[r_owner] && (r_cnt < CNT_W'(MAX_BURST));
   // A dropped burst hands over in the same cycle by scanning past the owner.
   assign w_start     = (r_state == BURST) ? w_owner_nxt : r_ptr;
   assign w_owner_oh  = NUM_REQ'(1) << r_owner;

   rr_pick #(.N(NUM_REQ), .IW(SRC_W)) u_pick (
      .i_valid  (req_valid),
      .i_start  (w_start),
      .o_onehot (w_pick_oh),
      .o_idx    (w_pick_idx),
      .o_any    (w_pick_any)
   );

   assign req_ready = (reset || flush) ? '0 : w_keep ? w_owner_oh : w_pick_oh;
   assign w_gidx    = w_keep ? r_owner : w_pick_idx;
   assign w_xfer    = |req_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wb_en   <= 1'b0;
         wb_addr <= '0;
         wb_data <= '0;
         wb_src  <= '0;
         r_ptr   <= '0;
         r_state <= IDLE;
         r_owner <= '0;
         r_cnt   <= '0;
      end else if (flush) begin
         wb_en   <= 1'b0;
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         wb_en <= w_xfer;
         if (w_xfer) begin
            wb_addr <= req_addr[int'(w_gidx)*ADDR_W +: ADDR_W];
            wb_data <= req_data[int'(w_gidx)*DATA_W +: DATA_W];
            wb_src  <= w_gidx;
         end
         if (w_keep) begin
            r_cnt <= w_cnt_inc;
            if (w_cnt_inc == CNT_W'(MAX_BURST)) begin
               r_state <= IDLE;
               r_ptr   <= w_owner_nxt;
            end
         end else begin
            if (r_state == BURST) r_ptr <= w_owner_nxt;
            r_state <= IDLE;
            r_cnt   <= '0;
            if (w_pick_any) begin
               if (MAX_BURST > 1) begin
                  r_state <= BURST;
                  r_owner <= w_pick_idx;
                  r_cnt   <= CNT_W'(1);
               end else begin
                  r_ptr <= w_pick_nxt;
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: table-driven, directed and randomized checks of two arbiter
// instances (MAX_BURST=2 and MAX_BURST=4) against a behavioural grant/write-back model.
module tb_regfile_wb_arbiter;
   import regfile_wb_arbiter_pkg::*;

   localparam int N  = 3;
   localparam int AW = 4;
   localparam int DW = 32;
   localparam int SW = 2;

   typedef struct {
      logic [N-1:0] v;
      logic         f;
      logic [N-1:0] e2;
      logic [N-1:0] e4;
   } tvec_t;

   logic            clk = 1'b0;
   logic            reset;
   logic            flush;
   logic [N-1:0]    req_valid;
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]    rdy [2];
   logic            en  [2];
   logic [AW-1:0]   wa  [2];
   logic [DW-1:0]   wd  [2];
   logic [SW-1:0]   ws  [2];

   int n_chk  = 0;
   int n_fail = 0;

   int      mb [2] = '{2, 4};
   int      m_ptr [2];
   int      m_owner [2];
   int      m_run [2];
   logic    m_en [2];
   int      m_src [2];
   wb_req_t m_wb [2];
   tvec_t   tbl [12];

   always #5 clk = ~clk;

   regfile_wb_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(2)) d2 (
      .clk(clk), .reset(reset), .flush(flush), .req_valid(req_valid), .req_addr(req_addr),
      .req_data(req_data), .req_ready(rdy[0]), .wb_en(en[0]), .wb_addr(wa[0]),
      .wb_data(wd[0]), .wb_src(ws[0])
   );

   regfile_wb_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(4)) d4 (
      .clk(clk), .reset(reset), .flush(flush), .req_valid(req_valid), .req_addr(req_addr),
      .req_data(req_data), .req_ready(rdy[1]), .wb_en(en[1]), .wb_addr(wa[1]),
      .wb_data(wd[1]), .wb_src(ws[1])
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Who the arbiter should grant right now: the burst owner while it stays valid and has
   // budget left, otherwise the first valid requester in round-robin order.
   function automatic int m_grant(input int k);
      int s;
      if (reset || flush) return -1;
      if (m_run[k] > 0 && req_valid[m_owner[k]]) return m_owner[k];
      s = (m_run[k] > 0) ? (m_owner[k] + 1) % N : m_ptr[k];
      for (int d = 0; d < N; d++)
         if (req_valid[(s + d) % N]) return (s + d) % N;
      return -1;
   endfunction

   function automatic logic [N-1:0] oh(input int g);
      return (g < 0) ? '0 : N'(1) << g;
   endfunction

   task automatic m_reset();
      for (int k = 0; k < 2; k++) begin
         m_ptr[k] = 0; m_owner[k] = 0; m_run[k] = 0; m_en[k] = 1'b0; m_src[k] = 0;
         m_wb[k] = '0;
      end
   endtask

   task automatic m_tick();
      int g;
      for (int k = 0; k < 2; k++) begin
         g = m_grant(k);
         if (flush) begin
            m_en[k] = 1'b0;
            m_run[k] = 0;
         end else begin
            m_en[k] = (g >= 0);
            if (g >= 0) begin
               m_wb[k].addr = req_addr[g*AW +: AW];
               m_wb[k].data = req_data[g*DW +: DW];
               m_src[k] = g;
            end
            if (m_run[k] > 0 && g == m_owner[k]) begin
               m_run[k]++;
               if (m_run[k] == mb[k]) begin
                  m_run[k] = 0;
                  m_ptr[k] = (m_owner[k] + 1) % N;
               end
            end else begin
               if (m_run[k] > 0) m_ptr[k] = (m_owner[k] + 1) % N;
               m_run[k] = 0;
               if (g >= 0) begin
                  if (mb[k] > 1) begin
                     m_owner[k] = g;
                     m_run[k] = 1;
                  end else begin
                     m_ptr[k] = (g + 1) % N;
                  end
               end
            end
         end
      end
   endtask

   task automatic sample();
      #4;
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("ready_mb%0d", mb[k]), 64'(rdy[k]), 64'(oh(m_grant(k))));
         chk($sformatf("wb_en_mb%0d", mb[k]), 64'(en[k]), 64'(m_en[k]));
         chk($sformatf("wb_addr_mb%0d", mb[k]), 64'(wa[k]), 64'(m_wb[k].addr));
         chk($sformatf("wb_data_mb%0d", mb[k]), 64'(wd[k]), 64'(m_wb[k].data));
         chk($sformatf("wb_src_mb%0d", mb[k]), 64'(ws[k]), 64'(m_src[k]));
      end
   endtask

   task automatic tick();
      @(posedge clk);
      m_tick();
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #1;
      m_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      tbl[0]  = '{3'b111, 1'b0, 3'b001, 3'b001};
      tbl[1]  = '{3'b111, 1'b0, 3'b001, 3'b001};
      tbl[2]  = '{3'b111, 1'b0, 3'b010, 3'b001};
      tbl[3]  = '{3'b111, 1'b0, 3'b010, 3'b001};
      tbl[4]  = '{3'b111, 1'b0, 3'b100, 3'b010};
      tbl[5]  = '{3'b111, 1'b0, 3'b100, 3'b010};
      tbl[6]  = '{3'b111, 1'b0, 3'b001, 3'b010};
      tbl[7]  = '{3'b111, 1'b0, 3'b001, 3'b010};
      tbl[8]  = '{3'b111, 1'b1, 3'b000, 3'b000};
      tbl[9]  = '{3'b111, 1'b0, 3'b010, 3'b100};
      tbl[10] = '{3'b001, 1'b0, 3'b001, 3'b001};
      tbl[11] = '{3'b000, 1'b0, 3'b000, 3'b000};

      reset     = 1'b1;
      flush     = 1'b0;
      req_valid = '1;
      req_addr  = {4'd3, 4'd2, 4'd1};
      req_data  = {32'h3333_0003, 32'h2222_0002, 32'h1111_0001};
      m_reset();
      #3;
      chk("rst_ready_mb2", 64'(rdy[0]), 64'(0));
      chk("rst_ready_mb4", 64'(rdy[1]), 64'(0));
      chk("rst_wb_en", 64'(en[0] | en[1]), 64'(0));
      chk("rst_wb_addr", 64'(wa[0] | wa[1]), 64'(0));
      @(posedge clk);
      #1;
      reset = 1'b0;

      foreach (tbl[i]) begin
         req_valid = tbl[i].v;
         flush     = tbl[i].f;
         sample();
         chk($sformatf("tbl%0d_ready_mb2", i), 64'(rdy[0]), 64'(tbl[i].e2));
         chk($sformatf("tbl%0d_ready_mb4", i), 64'(rdy[1]), 64'(tbl[i].e4));
         tick();
      end
      flush = 1'b0;

      do_reset();
      req_valid = 3'b010;
      req_addr[AW +: AW] = 4'd5;
      req_data[DW +: DW] = 32'hA5A5_A5A5;
      for (int c = 0; c < 6; c++) begin
         sample();
         chk("single_ready", 64'(rdy[1]), 64'(3'b010));
         if (c > 0) begin
            chk("single_wb_en", 64'(en[1]), 64'(1));
            chk("single_wb_addr", 64'(wa[1]), 64'(5));
            chk("single_wb_data", 64'(wd[1]), 64'(32'hA5A5_A5A5));
            chk("single_wb_src", 64'(ws[1]), 64'(1));
         end
         tick();
      end

      do_reset();
      req_valid = 3'b001;
      sample();
      tick();
      req_valid = 3'b100;
      sample();
      chk("early_ready_mb2", 64'(rdy[0]), 64'(3'b100));
      chk("early_ready_mb4", 64'(rdy[1]), 64'(3'b100));
      tick();
      chk("early_ptr_mb4", 64'(d4.r_ptr), 64'(1));

      do_reset();
      req_valid = 3'b111;
      for (int c = 0; c < 2; c++) begin
         sample();
         chk("fl_pre_ready_mb4", 64'(rdy[1]), 64'(3'b001));
         tick();
      end
      flush = 1'b1;
      sample();
      chk("fl_ready_mb2", 64'(rdy[0]), 64'(0));
      chk("fl_ready_mb4", 64'(rdy[1]), 64'(0));
      chk("fl_wb_completes", 64'(en[1]), 64'(1));
      tick();
      flush = 1'b0;
      sample();
      chk("fl_post_wb_en", 64'(en[0] | en[1]), 64'(0));
      chk("fl_post_ready_mb2", 64'(rdy[0]), 64'(3'b010));
      chk("fl_post_ready_mb4", 64'(rdy[1]), 64'(3'b001));
      tick();

      req_valid = 3'b111;
      sample();
      tick();
      chk("arst_pre_wb_en", 64'(en[1]), 64'(1));
      #2;
      reset = 1'b1;
      #1;
      chk("arst_wb_en", 64'(en[0] | en[1]), 64'(0));
      chk("arst_wb_addr", 64'(wa[0] | wa[1]), 64'(0));
      chk("arst_wb_data", 64'(wd[0] | wd[1]), 64'(0));
      m_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;
      req_valid = 3'b110;
      sample();
      chk("arst_post_ready", 64'(rdy[1]), 64'(3'b010));
      tick();

      for (int c = 0; c < 400; c++) begin
         req_valid = N'($urandom);
         flush     = ($urandom_range(0, 15) == 0);
         req_addr  = (N*AW)'($urandom);
         req_data  = {$urandom, $urandom, $urandom};
         sample();
         tick();
      end
      flush = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter for the SIMD register file's single write port. It collects write requests from up to NUM_REQ producers (vector ALU, load unit, scalar unit) and grants the port round-robin, allowing a bounded burst per producer. Each accepted write goes to a registered output stage that drives the register-file write port one cycle later.

## Interface
Parameters:
- NUM_REQ, 3, number of requesters (≥2)
- ADDR_W, 4, register-index width
- DATA_W, 32, write-data width
- MAX_BURST, 4, maximum consecutive grants to one requester (≥1)

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high
- flush  input  1  synchronous pipeline flush
- req_valid  input  NUM_REQ  per-requester write request
- req_addr  input  NUM_REQ*ADDR_W  packed destination indices; requester i occupies slice [i*ADDR_W +: ADDR_W]
- req_data  input  NUM_REQ*DATA_W  packed write data, same packing as req_addr
- req_ready  output  NUM_REQ  one-hot grant (combinational)
- wb_en  output  1  register-file write enable
- wb_addr  output  ADDR_W  register-file write index
- wb_data  output  DATA_W  register-file write data
- wb_src  output  SRC_W  index of the requester that produced the current write

## Operation
- A transfer happens on requester i when req_valid[i] && req_ready[i] at a rising clock edge.
- req_ready is at most one-hot. It is combinational from req_valid and the registered state only. It never depends on addr or data.
- Registered state:
  - ptr: round-robin start index.
  - state: IDLE or BURST.
  - owner: index of the requester holding the burst.
  - cnt: grants already given to owner.
- Selection in IDLE: grant the first valid requester found by scanning ptr, ptr+1, … (mod NUM_REQ).
  - On a grant with MAX_BURST>1: state→BURST, owner←i, cnt←1.
  - On a grant with MAX_BURST=1: state stays IDLE and ptr←i+1 mod NUM_REQ.
  - With no valid requester: no grant, state unchanged.
- Selection in BURST:
  - If req_valid[owner] && cnt<MAX_BURST: grant owner and increment cnt.
  - If the grant makes cnt reach MAX_BURST: state→IDLE and ptr←owner+1.
  - If owner drops valid: the burst ends in that same cycle with no bubble. Select using the IDLE scan starting at owner+1, and set ptr←owner+1.
- Output stage, updated every cycle:
  - wb_en ← a transfer occurred.
  - On a transfer, wb_addr, wb_data and wb_src ← the granted requester's values.
  - With no transfer, wb_addr, wb_data and wb_src hold their previous values.
- flush:
  - In the flush cycle, req_ready is all zeros, so no transfer occurs.
  - At the edge that ends the flush cycle: wb_en←0, state←IDLE, cnt←0.
  - ptr is unchanged.
  - A write already in the output stage still completes in the flush cycle.
- reset, asynchronous: wb_en=0, wb_addr=0, wb_data=0, wb_src=0, ptr=0, state=IDLE, owner=0, cnt=0. req_ready is forced to zero while reset is high.
- Simultaneous events:
  - flush overrides every grant.
  - Reset overrides flush.
  - If reset asserts in the middle of a burst, the burst is abandoned and the next grant follows the IDLE rule from ptr=0.

## Timing
- Grant latency: 0 cycles. req_ready asserts in the same cycle that req_valid is presented, if the request is selected.
- Write latency: 1 cycle. A transfer at edge k gives wb_en=1 in cycle k+1 with that transfer's addr, data and source.
- Throughput: one write per cycle. Back-to-back grants are possible, including across burst hand-over.
- A requester must hold valid, addr and data stable until it receives ready. The arbiter does not check this.
- Fairness: any continuously valid requester is granted within (NUM_REQ−1)*MAX_BURST cycles.

## Structure
- The SIMD shared package holds:
  - the state enum (IDLE, BURST);
  - SRC_W = $clog2(NUM_REQ), defined locally as max(1, …);
  - a `wb_req_t` struct {addr, data} for bench use.
- One sub-module: `rr_pick`. It is combinational: from a valid vector and a start index it returns a one-hot vector and an index. It is instantiated once.
- The output stage registers are coded inline in this block.

## Test plan
- Reset: hold reset with all valid=1 → req_ready=000. After release, wb_en=0 and wb_addr=0; the first grant goes to req 0 (ptr=0).
- Single requester: req 1 valid for 6 cycles, MAX_BURST=4, addr=5, data=0xA5A5A5A5. Required response:
  - grants in 6 consecutive cycles;
  - wb_en=1 from the cycle after the first grant, wb_addr=5, wb_src=1;
  - state→IDLE after the 4th grant, then re-grant to req 1 with no bubble.
- Rotation: all 3 requesters continuously valid, MAX_BURST=2 → grant sequence 0,0,1,1,2,2,0,0 with no idle cycles.
- Early release: req 0 bursting with cnt=1 drops valid while req 2 is valid → req 2 is granted that same cycle and ptr=1.
- Flush in mid-burst: grant sequence 0,0, then flush in the third cycle → req_ready=000 in that cycle and wb_en=0 in the next cycle. The following grant scans from the unchanged ptr.
- Asynchronous reset between edges while wb_en=1 → wb_en, wb_addr and wb_data go to 0 immediately without waiting for a clock edge.
